// File: rtl/bch_chien_search_flow.sv
// Parallel Chien search: evaluates the BCH error locator at C_THREAD_NUM positions per
// cycle and streams a per-bit error mask with root count and decode-failure flag.
module bch_chien_search_flow #(
    parameter int C_PRIMPOLY_ORDER = 14,
    parameter int C_COEF_NUM       = 43,
    parameter int C_TOTALBIT_NUM   = 8832,
    parameter int C_THREAD_NUM     = 8,
    parameter logic [C_PRIMPOLY_ORDER:0] C_PRIMPOLY = 15'h4443,
    localparam int DW = $clog2(C_COEF_NUM + 2)
) (
    input  logic                                        I_clk,
    input  logic                                        I_rst,
    input  logic [C_PRIMPOLY_ORDER*(C_COEF_NUM+1)-1:0]  I_coef,
    input  logic [DW-1:0]                               I_deg,
    input  logic                                        I_coef_v,
    output logic                                        O_coef_rdy,
    output logic [C_THREAD_NUM-1:0]                     O_data,
    output logic                                        O_data_v,
    output logic                                        O_data_sof,
    output logic                                        O_data_eof,
    input  logic                                        I_data_rdy,
    output logic [DW-1:0]                               O_err_cnt,
    output logic                                        O_fail
);
    localparam int M          = C_PRIMPOLY_ORDER;
    localparam int K1         = C_COEF_NUM + 1;
    localparam int T          = C_THREAD_NUM;
    localparam int N          = C_TOTALBIT_NUM;
    localparam int NN         = (1 << M) - 1;
    localparam int S          = NN - N;
    localparam int W          = (N + T - 1) / T;
    localparam int LAST_VALID = N - (W - 1) * T;
    localparam int WCW        = $clog2(W + 1);
    localparam int PW         = $clog2(T + 1);
    localparam int CMAX       = (1 << DW) - 1;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M:0]   x;
        r = '0;
        x = {1'b0, a};
        for (int i = 0; i < M; i++) begin
            if (b[i]) r ^= x[M-1:0];
            x = {x[M-1:0], 1'b0};
            if (x[M]) x ^= C_PRIMPOLY;
        end
        return r;
    endfunction

    function automatic logic [M-1:0] gf_pow(input int e);
        logic [M-1:0] r;
        logic [M-1:0] b;
        int           ee;
        ee = e % NN;
        r  = M'(1);
        b  = M'(2);
        for (int i = 0; i < 31; i++) begin
            if (ee[i]) r = gf_mul(r, b);
            b = gf_mul(b, b);
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wcnt;
    logic [DW-1:0]    deg_q;
    logic             accept, stall, en, s1_v, adv, last_word;
    logic [T*M-1:0]   sum_flat;
    logic             s2_v, s2_sof, s2_last;
    logic             s3_v, s3_sof, s3_last;
    logic [T-1:0]     zero_r;
    logic [PW-1:0]    pop;
    logic [DW+PW-1:0] cnt_sum;
    logic [DW-1:0]    cnt_sat;

    assign O_coef_rdy = (state_q == IDLE);
    assign accept     = I_coef_v && O_coef_rdy;
    assign stall      = O_data_v && !I_data_rdy;
    assign en         = !stall;
    assign s1_v       = (state_q == LOAD) || (state_q == RUN);
    assign adv        = s1_v && en;
    assign last_word  = (wcnt == WCW'(W - 1));

    always_ff @(posedge I_clk) begin
        if (I_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = LOAD;
            LOAD, RUN: if (adv) state_d = last_word ? DRAIN : RUN;
            DRAIN:     if (O_data_v && I_data_rdy && O_data_eof) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wcnt  <= '0;
            deg_q <= '0;
        end else if (accept) begin
            wcnt  <= '0;
            deg_q <= I_deg;
        end else if (adv && !last_word) begin
            wcnt  <= wcnt + 1'b1;
        end
    end

    // Thread j, term k starts at Lambda_k*alpha^(k*(S+1+j)) and steps by alpha^(k*T).
    for (genvar gj = 0; gj < T; gj++) begin : g_thr
        logic [K1*M-1:0] terms;
        logic [M-1:0]    sum_c;
        logic [M-1:0]    sum_r;

        for (genvar gk = 0; gk < K1; gk++) begin : g_k
            localparam logic [M-1:0] C_LD = gf_pow(gk * (S + 1 + gj));
            localparam logic [M-1:0] C_ST = gf_pow(gk * T);
            logic [M-1:0] term;
            always_ff @(posedge I_clk) begin
                if (I_rst)       term <= '0;
                else if (accept) term <= gf_mul(I_coef[M*gk +: M], C_LD);
                else if (adv)    term <= gf_mul(term, C_ST);
            end
            assign terms[M*gk +: M] = term;
        end

        always_comb begin
            sum_c = '0;
            for (int k = 0; k < K1; k++) sum_c ^= terms[M*k +: M];
        end

        always_ff @(posedge I_clk) begin
            if (I_rst)   sum_r <= '0;
            else if (en) sum_r <= sum_c;
        end
        assign sum_flat[M*gj +: M] = sum_r;
    end

    always_comb begin
        pop = '0;
        for (int j = 0; j < T; j++) pop = pop + PW'(zero_r[j]);
        cnt_sum = (DW+PW)'(O_err_cnt) + (DW+PW)'(pop);
        cnt_sat = (cnt_sum > (DW+PW)'(CMAX)) ? DW'(CMAX) : cnt_sum[DW-1:0];
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            s2_v <= 1'b0; s2_sof <= 1'b0; s2_last <= 1'b0;
            s3_v <= 1'b0; s3_sof <= 1'b0; s3_last <= 1'b0;
            zero_r     <= '0;
            O_data     <= '0;
            O_data_v   <= 1'b0;
            O_data_sof <= 1'b0;
            O_data_eof <= 1'b0;
        end else if (en) begin
            s2_v    <= s1_v;
            s2_sof  <= s1_v && (wcnt == '0);
            s2_last <= s1_v && last_word;
            s3_v    <= s2_v;
            s3_sof  <= s2_sof;
            s3_last <= s2_last;
            // Positions beyond the codeword in the final word never report a root.
            for (int j = 0; j < T; j++)
                zero_r[j] <= s2_v && (sum_flat[M*j +: M] == '0) && (!s2_last || j < LAST_VALID);
            O_data     <= s3_v ? zero_r : '0;
            O_data_v   <= s3_v;
            O_data_sof <= s3_v && s3_sof;
            O_data_eof <= s3_v && s3_last;
        end
    end

    // The count is advanced as a word enters the output register, so the eof word already shows the total.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_err_cnt <= '0;
            O_fail    <= 1'b0;
        end else if (accept) begin
            O_err_cnt <= '0;
            O_fail    <= 1'b0;
        end else if (en && s3_v) begin
            O_err_cnt <= cnt_sat;
            if (s3_last) O_fail <= (cnt_sat != deg_q) || (deg_q > DW'(C_COEF_NUM));
        end
    end

endmodule

// File: tb/tb_bch_chien_search_flow.sv
// Scoreboard bench for bch_chien_search_flow: a log/antilog GF model evaluates the
// locator at every position and queues expected mask words for a negedge monitor.
module tb_bch_chien_search_flow;
    localparam int M  = 14;
    localparam int K1 = 44;
    localparam int TH = 8;
    localparam int N1 = 8832;
    localparam int N2 = 8833;
    localparam int NN = 16383;
    localparam int DW = 6;

    logic I_clk = 1'b0;
    logic I_rst = 1'b1;
    always #5 I_clk = ~I_clk;

    logic [M*K1-1:0] coef = '0;
    logic [DW-1:0]   deg  = '0;
    logic            cv1 = 1'b0, cv2 = 1'b0, rdy = 1'b1;
    logic            crdy1, v1, sof1, eof1, fail1;
    logic            crdy2, v2, sof2, eof2, fail2;
    logic [TH-1:0]   data1, data2;
    logic [DW-1:0]   cnt1, cnt2;

    bch_chien_search_flow dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_coef(coef), .I_deg(deg), .I_coef_v(cv1),
        .O_coef_rdy(crdy1), .O_data(data1), .O_data_v(v1), .O_data_sof(sof1),
        .O_data_eof(eof1), .I_data_rdy(rdy), .O_err_cnt(cnt1), .O_fail(fail1));

    bch_chien_search_flow #(.C_TOTALBIT_NUM(N2)) dut2 (
        .I_clk(I_clk), .I_rst(I_rst), .I_coef(coef), .I_deg(deg), .I_coef_v(cv2),
        .O_coef_rdy(crdy2), .O_data(data2), .O_data_v(v2), .O_data_sof(sof2),
        .O_data_eof(eof2), .I_data_rdy(rdy), .O_err_cnt(cnt2), .O_fail(fail2));

    typedef struct packed {
        logic [TH-1:0] d;
        logic          sof;
        logic          eof;
    } word_t;

    word_t exp_q[$];
    int    exp_t[NN];
    int    log_t[NN+1];
    int    lam[K1];
    int    errs[$];
    int    vectors = 0, miscompares = 0;
    int    xfers = 0, eofs = 0;
    int    exp_cnt = 0;
    bit    exp_fail = 1'b0;
    bit    use2 = 1'b0;

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % NN];
    endfunction

    task automatic build_tables();
        int x = 1;
        for (int i = 0; i < NN; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x << 1;
            if ((x & 16384) != 0) x = x ^ 'h4443;
        end
    endtask

    // Lambda(x) = prod(1 + beta_i x), beta_i = alpha^-(S+1+p_i)
    task automatic build_lambda(input int n);
        int e, beta;
        for (int k = 0; k < K1; k++) lam[k] = 0;
        lam[0] = 1;
        foreach (errs[i]) begin
            e    = (NN - n + 1 + errs[i]) % NN;
            beta = exp_t[(NN - e) % NN];
            for (int k = K1 - 1; k >= 1; k--) lam[k] = lam[k] ^ gmul(lam[k-1], beta);
        end
        for (int k = 0; k < K1; k++) coef[M*k +: M] = M'(lam[k]);
    endtask

    task automatic push_frame(input int n, input int d);
        int    w, p, e, v, cnt;
        word_t wd;
        w   = (n + TH - 1) / TH;
        cnt = 0;
        for (int i = 0; i < w; i++) begin
            wd.d   = '0;
            wd.sof = (i == 0);
            wd.eof = (i == w - 1);
            for (int b = 0; b < TH; b++) begin
                p = i * TH + b;
                if (p < n) begin
                    e = (NN - n + 1 + p) % NN;
                    v = lam[K1-1];
                    for (int k = K1 - 2; k >= 0; k--) v = gmul(v, exp_t[e]) ^ lam[k];
                    if (v == 0) begin
                        wd.d[b] = 1'b1;
                        cnt++;
                    end
                end
            end
            exp_q.push_back(wd);
        end
        exp_cnt  = (cnt > 63) ? 63 : cnt;
        exp_fail = (exp_cnt != d) || (d > 43);
        deg      = DW'(d);
    endtask

    logic          m_v, m_sof, m_eof, m_fail, stalled;
    logic [TH-1:0] m_d;
    logic [DW-1:0] m_cnt;
    word_t         hold, got, e_w;

    always @(negedge I_clk) begin
        m_v    = use2 ? v2    : v1;
        m_d    = use2 ? data2 : data1;
        m_sof  = use2 ? sof2  : sof1;
        m_eof  = use2 ? eof2  : eof1;
        m_cnt  = use2 ? cnt2  : cnt1;
        m_fail = use2 ? fail2 : fail1;
        got    = {m_d, m_sof, m_eof};
        if (m_v) begin
            if (stalled) begin
                vectors++;
                if (got !== hold) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %h, required %h", got, hold);
                end
            end
            if (rdy) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_underflow: got word %h with nothing expected", got);
                end else begin
                    e_w = exp_q.pop_front();
                    if (got !== e_w) begin
                        miscompares++;
                        $display("FAIL word[%0d]: got d=%h sof=%b eof=%b, required d=%h sof=%b eof=%b",
                                 xfers, m_d, m_sof, m_eof, e_w.d, e_w.sof, e_w.eof);
                    end
                end
                if (m_eof) begin
                    vectors += 2;
                    if (m_cnt !== DW'(exp_cnt)) begin
                        miscompares++;
                        $display("FAIL eof_err_cnt: got %0d, required %0d", m_cnt, exp_cnt);
                    end
                    if (m_fail !== exp_fail) begin
                        miscompares++;
                        $display("FAIL eof_fail: got %b, required %b", m_fail, exp_fail);
                    end
                    eofs++;
                end
                xfers++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hold    = got;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic accept(input bit sel2);
        @(posedge I_clk); #1;
        if (sel2) cv2 = 1'b1; else cv1 = 1'b1;
        @(posedge I_clk); #1;
        cv1 = 1'b0;
        cv2 = 1'b0;
    endtask

    task automatic wait_eof(input int target, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (eofs < target) begin
            @(posedge I_clk); #1;
            n++;
            if (n > 5000) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        I_rst = 1'b1;
        repeat (3) @(posedge I_clk);
        #1 I_rst = 1'b0;
        vectors += 8;
        if (crdy1 !== 1'b1) begin miscompares++; $display("FAIL rst_coef_rdy: got %b, required 1", crdy1); end
        if (crdy2 !== 1'b1) begin miscompares++; $display("FAIL rst_coef_rdy2: got %b, required 1", crdy2); end
        if (v1 !== 1'b0)    begin miscompares++; $display("FAIL rst_data_v: got %b, required 0", v1); end
        if (data1 !== '0)   begin miscompares++; $display("FAIL rst_data: got %h, required 0", data1); end
        if (sof1 !== 1'b0)  begin miscompares++; $display("FAIL rst_sof: got %b, required 0", sof1); end
        if (eof1 !== 1'b0)  begin miscompares++; $display("FAIL rst_eof: got %b, required 0", eof1); end
        if (cnt1 !== '0)    begin miscompares++; $display("FAIL rst_err_cnt: got %0d, required 0", cnt1); end
        if (fail1 !== 1'b0) begin miscompares++; $display("FAIL rst_fail: got %b, required 0", fail1); end
    endtask

    task automatic test_zero_errors();
        int k = 0;
        errs = {};
        build_lambda(N1);
        push_frame(N1, 0);
        accept(1'b0);
        while (k < 20) begin
            @(negedge I_clk);
            k++;
            if (v1) break;
        end
        vectors += 2;
        if (k !== 4)    begin miscompares++; $display("FAIL sof_latency: got %0d cycles, required 4", k); end
        if (sof1 !== 1) begin miscompares++; $display("FAIL first_sof: got %b, required 1", sof1); end
        while (!(v1 && eof1) && k < 1300) begin
            @(negedge I_clk);
            k++;
        end
        vectors += 3;
        if (k !== 1107)  begin miscompares++; $display("FAIL eof_latency: got %0d cycles, required 1107", k); end
        if (crdy1 !== 0) begin miscompares++; $display("FAIL rdy_at_eof: got %b, required 0", crdy1); end
        @(negedge I_clk);
        if (crdy1 !== 1) begin miscompares++; $display("FAIL rdy_after_eof: got %b, required 1", crdy1); end
    endtask

    task automatic test_single_error(input int d);
        bit ok;
        int e0 = eofs;
        errs = {100};
        build_lambda(N1);
        push_frame(N1, d);
        accept(1'b0);
        wait_eof(e0 + 1, ok);
        vectors += 3;
        if (!ok)          begin miscompares++; $display("FAIL single_timeout: got no eof, required eof"); end
        if (cnt1 !== 1)   begin miscompares++; $display("FAIL single_cnt d=%0d: got %0d, required 1", d, cnt1); end
        if (fail1 !== (d != 1)) begin miscompares++; $display("FAIL single_fail d=%0d: got %b, required %b", d, fail1, d != 1); end
    endtask

    task automatic test_back_pressure();
        int e0 = eofs;
        int x0 = xfers;
        int n  = 0;
        errs = {0, 4000, 8831};
        build_lambda(N1);
        push_frame(N1, 3);
        accept(1'b0);
        while (n < 6000) begin
            vectors++;
            if (crdy1 !== (eofs > e0)) begin
                miscompares++;
                $display("FAIL bp_coef_rdy: got %b, required %b", crdy1, eofs > e0);
            end
            if (eofs > e0) break;
            rdy = 1'($urandom_range(0, 1));
            @(posedge I_clk); #1;
            n++;
        end
        rdy = 1'b1;
        vectors += 3;
        if (n >= 6000)          begin miscompares++; $display("FAIL bp_timeout: got no eof, required eof"); end
        if (xfers - x0 !== 1104) begin miscompares++; $display("FAIL bp_words: got %0d, required 1104", xfers - x0); end
        if (cnt1 !== 3)          begin miscompares++; $display("FAIL bp_cnt: got %0d, required 3", cnt1); end
    endtask

    task automatic test_tail();
        bit ok;
        int e0 = eofs;
        int x0 = xfers;
        use2 = 1'b1;
        errs = {8832, 8835};
        build_lambda(N2);
        push_frame(N2, 2);
        accept(1'b1);
        wait_eof(e0 + 1, ok);
        vectors += 4;
        if (!ok)                 begin miscompares++; $display("FAIL tail_timeout: got no eof, required eof"); end
        if (xfers - x0 !== 1105) begin miscompares++; $display("FAIL tail_words: got %0d, required 1105", xfers - x0); end
        if (cnt2 !== 1)          begin miscompares++; $display("FAIL tail_cnt: got %0d, required 1", cnt2); end
        if (fail2 !== 1)         begin miscompares++; $display("FAIL tail_fail: got %b, required 1", fail2); end
        use2 = 1'b0;
    endtask

    task automatic test_reset_and_ignored();
        bit ok;
        int n  = 0;
        int x0 = xfers;
        int e0;
        errs = {50, 6000};
        build_lambda(N1);
        push_frame(N1, 2);
        accept(1'b0);
        while (xfers - x0 < 500 && n < 2000) begin
            @(posedge I_clk); #1;
            n++;
        end
        I_rst = 1'b1;
        @(posedge I_clk); #1;
        I_rst = 1'b0;
        exp_q.delete();
        e0 = eofs;
        vectors += 5;
        if (v1 !== 0)    begin miscompares++; $display("FAIL mid_rst_v: got %b, required 0", v1); end
        if (crdy1 !== 1) begin miscompares++; $display("FAIL mid_rst_rdy: got %b, required 1", crdy1); end
        if (data1 !== 0) begin miscompares++; $display("FAIL mid_rst_data: got %h, required 0", data1); end
        if (eof1 !== 0)  begin miscompares++; $display("FAIL mid_rst_eof: got %b, required 0", eof1); end
        if (cnt1 !== 0)  begin miscompares++; $display("FAIL mid_rst_cnt: got %0d, required 0", cnt1); end

        errs = {7, 1234, 8000};
        build_lambda(N1);
        push_frame(N1, 3);
        x0  = xfers;
        cv1 = 1'b1;
        @(posedge I_clk); #1;
        cv1 = 1'b0;
        n = 0;
        while (xfers - x0 < 100 && n < 2000) begin
            @(posedge I_clk); #1;
            n++;
        end
        coef = {K1{14'h1abc}};
        deg  = DW'(5);
        cv1  = 1'b1;
        repeat (3) begin
            vectors++;
            if (crdy1 !== 0) begin miscompares++; $display("FAIL run_coef_rdy: got %b, required 0", crdy1); end
            @(posedge I_clk); #1;
        end
        cv1 = 1'b0;
        wait_eof(e0 + 1, ok);
        vectors += 4;
        if (!ok)                 begin miscompares++; $display("FAIL ign_timeout: got no eof, required eof"); end
        if (xfers - x0 !== 1104) begin miscompares++; $display("FAIL ign_words: got %0d, required 1104", xfers - x0); end
        if (cnt1 !== 3)          begin miscompares++; $display("FAIL ign_cnt: got %0d, required 3", cnt1); end
        if (fail1 !== 0)         begin miscompares++; $display("FAIL ign_fail: got %b, required 0", fail1); end
    endtask

    initial begin
        stalled = 1'b0;
        hold    = '0;
        build_tables();
        test_reset();
        test_zero_errors();
        test_single_error(1);
        test_single_error(2);
        test_single_error(44);
        test_back_pressure();
        test_tail();
        test_reset_and_ignored();
        repeat (4) @(posedge I_clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d words pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bch_chien_search_flow.md
Name: bch_chien_search_flow

Overview:
Second-generation parallel Chien search for the configurable BCH decoder. It evaluates the error-locator polynomial over the shortened codeword, C_THREAD_NUM positions per cycle, and emits a per-bit error mask. Additions over the first generation:
- explicit accept handshake
- output back-pressure (stall)
- masking of the tail word
- root counting, with a decode-failure flag when the root count does not equal the locator degree

It sits between the Berlekamp-Massey block and the correction XOR stage.

Parameters:
C_PRIMPOLY_ORDER, 14, GF(2^m) order m
C_COEF_NUM, 43, correction capability t (highest locator degree)
C_TOTALBIT_NUM, 8832, shortened codeword length N in bits (data + parity)
C_THREAD_NUM, 8, positions evaluated per cycle; 1..64
C_PRIMPOLY, 15'h4443, primitive polynomial; bit m set

Ports:
I_clk  in  1  clock
I_rst  in  1  reset
I_coef  in  m*(t+1)  locator Λ0..Λt; Λk at [m*k +: m]
I_deg  in  DW=GETASIZE(t+2)  locator degree reported by BM
I_coef_v  in  1  coefficient valid
O_coef_rdy  out  1  block idle, can accept
O_data  out  C_THREAD_NUM  error mask word
O_data_v  out  1  mask word valid
O_data_sof  out  1  first word of frame
O_data_eof  out  1  last word of frame
I_data_rdy  in  1  downstream ready
O_err_cnt  out  DW  roots found in frame
O_fail  out  1  decode failure

Behaviour:
- Reset I_rst, synchronous, active-high; clock I_clk.
- Reset values:
  - O_coef_rdy=1.
  - O_data, O_data_v, O_data_sof, O_data_eof, O_err_cnt and O_fail all 0.
  - FSM in IDLE.
- Constants:
  - S = 2^m-1-N.
  - W = ceil(N/C_THREAD_NUM) words per frame.
  - Position p (0..N-1, p=0 is the first transmitted bit) maps to word p/C_THREAD_NUM, bit p%C_THREAD_NUM.
  - The bit is 1 iff Λ(α^(S+1+p)) == 0.
- Handshakes:
  - Accept occurs on a cycle with I_coef_v && O_coef_rdy; I_coef and I_deg are latched on that cycle.
  - I_coef_v while O_coef_rdy=0 is ignored; there is no queueing.
  - An output word transfers on a cycle with O_data_v && I_data_rdy.
- FSM states and transitions:
  - IDLE: O_coef_rdy=1. Goes to LOAD on accept.
  - LOAD (1 cycle): multiply each Λk by α^(k*(S+1)), then go to RUN.
  - RUN: each thread j holds Λk·α^(k*(base+j)); per advance, all terms step by α^(k*C_THREAD_NUM). A word counter runs 0..W-1. Goes to DRAIN after word W-1 is issued into the pipeline.
  - DRAIN: wait until the eof word has transferred, then return to IDLE. O_coef_rdy rises the cycle after the eof transfer.
- Pipeline and latency:
  - Stages: multiply/update register → XOR-sum register → zero-compare register → output register.
  - With I_data_rdy held high, the first word appears with O_data_v=1, O_data_sof=1 exactly 4 cycles after the accept cycle.
  - Words are back-to-back; eof falls on the W-th word.
  - W=1 gives sof and eof on the same word.
- Stall: when O_data_v=1 and I_data_rdy=0:
  - All pipeline and counter registers hold.
  - O_data, sof and eof hold stable.
  - No word is dropped or duplicated.
- Tail mask: in the last word, bits for p ≥ N are forced to 0 and are not counted.
- Root counting:
  - O_err_cnt accumulates the popcount of each transferred word, saturating at 2^DW-1.
  - The final value is valid on the eof word and held until the next accept. O_err_cnt clears to 0 on accept.
- Failure flag:
  - Asserted with the eof word if either holds: final count ≠ latched I_deg; or latched I_deg > t.
  - Held until the next accept; clears to 0 on accept.
- Λ0 is expected to be 1. No check is made; the block evaluates whatever value is given.
- Reset mid-frame: all state returns to reset values on the next edge. No eof is emitted, and a new accept is possible on the first cycle after reset deasserts.

Test Plan:
- Zero errors, defaults. Λ=1 (Λ0=1, others 0), I_deg=0, rdy=1 → 1104 words, all zero; sof at accept+4; eof at accept+1107; O_err_cnt=0, O_fail=0.
- Single error at p=100. Λ0=1, Λ1=α^-(7652), I_deg=1 → only word 12 bit 4 is set; O_err_cnt=1, O_fail=0.
- Degree mismatch. Same Λ as the single-error case with I_deg=2 → same mask; O_err_cnt=1, O_fail=1. Separately, I_deg=44 → O_fail=1.
- Back-pressure. Random I_data_rdy at 50% duty on a 3-error frame → 1104 words transferred in order; outputs stable while stalled; the mask matches the reference model; O_coef_rdy=0 until the cycle after the eof transfer.
- Tail mask. N=8833, C_THREAD_NUM=8 → W=1105; last-word bits 1..7 are 0 even if Λ has roots there; an error at p=8832 sets last-word bit 0.
- Reset and ignored input. I_rst asserted during word 500 → outputs 0 and O_coef_rdy=1 next cycle, with no eof. I_coef_v pulsed during RUN is ignored, and the frame completes unaffected.
